// File: rtl/line_clear_engine_pkg.sv
// -----------------------------------------------------------------------------
// lineclear_pkg
// Shared types and constants for the line-clear engine:
//   - lc_state_t  : engine FSM states (IDLE, SCAN, FINISH)
//   - PTS_*       : points awarded for 0..4 cleared lines and the step above 4
//   - COMBO_MAX   : saturation value of the combo counter
//   - line_points : points(n) for n lines cleared in one evaluation
// -----------------------------------------------------------------------------
package lineclear_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } lc_state_t;

  localparam logic [31:0] PTS_0    = 32'd0;
  localparam logic [31:0] PTS_1    = 32'd1;
  localparam logic [31:0] PTS_2    = 32'd3;
  localparam logic [31:0] PTS_3    = 32'd5;
  localparam logic [31:0] PTS_4    = 32'd8;
  localparam logic [31:0] PTS_STEP = 32'd2;

  localparam logic [3:0]  COMBO_MAX = 4'd15;

  // Points for n lines: fixed table up to 3, then 8 plus 2 per extra line.
  function automatic logic [31:0] line_points(input logic [31:0] n);
    logic [31:0] pts;
    case (n)
      32'd0:   pts = PTS_0;
      32'd1:   pts = PTS_1;
      32'd2:   pts = PTS_2;
      32'd3:   pts = PTS_3;
      default: pts = PTS_4 + PTS_STEP * (n - 32'd4);
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/line_clear_engine_row_shift.sv
// -----------------------------------------------------------------------------
// row_shift
// Combinational removal of one row from the board. Row 0 is the top.
// Rows 1..row_i take rows 0..row_i-1, row 0 becomes empty, and rows below
// row_i pass through unchanged.
// Ports:
//   board_i : input board, 1 = occupied cell
//   row_i   : index of the row to remove
//   board_o : board with row_i removed and the rows above shifted down
// -----------------------------------------------------------------------------
module row_shift #(
  parameter  int ROWS = 20,
  parameter  int COLS = 10,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS-1:0][COLS-1:0] board_i,
  input  logic [RW-1:0]             row_i,
  output logic [ROWS-1:0][COLS-1:0] board_o
);

  // Shift every row at or above the removed row down by one; the top row
  // always receives an empty row.
  always_comb begin
    board_o = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (row_i >= RW'(r)) begin
        board_o[r] = board_i[r-1];
      end else begin
        board_o[r] = board_i[r];
      end
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// -----------------------------------------------------------------------------
// line_clear_engine
// On a start pulse the engine latches a board, scans it bottom-up one row per
// cycle, removes every full row (rechecking the same index after a shift so
// cascaded full rows are caught), then reports the number of cleared lines
// and updates saturating score / total-lines accumulators.
//
// Optional feature macro: LINECLEAR_COMBO_EN
//   defined   : combo counts consecutive clearing evaluations (saturating at
//               15) and its pre-increment value is added as a score bonus.
//   undefined : combo stays 0 and no bonus is added.
//
// Ports:
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   start_i         : begin an evaluation (accepted only in IDLE)
//   clear_score_i   : synchronous clear of score, total lines and combo
//   board_i         : board to evaluate, row 0 is the top
//   board_o         : working / cleared board
//   busy_o          : high while scanning or finishing
//   done_o          : one-cycle pulse marking the end of an evaluation
//   lines_cleared_o : rows removed by the last evaluation
//   score_o         : running score, saturating
//   total_lines_o   : running count of cleared lines, saturating
//   combo_o         : consecutive clearing evaluations
// -----------------------------------------------------------------------------
module line_clear_engine
  import lineclear_pkg::*;
#(
  parameter  int ROWS    = 20,
  parameter  int COLS    = 10,
  parameter  int SCORE_W = 16,
  parameter  int LINES_W = 16,
  localparam int CNT_W   = $clog2(ROWS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      clear_score_i,
  input  logic [ROWS-1:0][COLS-1:0] board_i,
  output logic [ROWS-1:0][COLS-1:0] board_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          lines_cleared_o,
  output logic [SCORE_W-1:0]        score_o,
  output logic [LINES_W-1:0]        total_lines_o,
  output logic [3:0]                combo_o
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SUM_W = SCORE_W + 1;
  localparam int TOT_W = LINES_W + 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  lc_state_t state_q, state_d;

  logic [ROWS-1:0][COLS-1:0] board_q, board_d, shifted_s;
  logic [RW-1:0]             row_q, row_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          lines_q, lines_d;
  logic [SCORE_W-1:0]        score_q, score_d, score_sat_s;
  logic [LINES_W-1:0]        total_q, total_d, total_sat_s;
  logic [3:0]                combo_q, combo_d, combo_next_s;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      row_full_s;

  logic [SUM_W-1:0]          pts_s, bonus_s, score_sum_s;
  logic [TOT_W-1:0]          total_sum_s;

  row_shift #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_row_shift (
    .board_i (board_q),
    .row_i   (row_q),
    .board_o (shifted_s)
  );

  assign row_full_s = &board_q[row_q];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a full row keeps the scan on the same index.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!row_full_s && (row_q == '0)) begin
          state_d = FINISH;
        end else begin
          state_d = SCAN;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they are registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      IDLE:    begin busy_d = 1'b0; done_d = 1'b0; end
      SCAN:    begin busy_d = 1'b1; done_d = 1'b0; end
      FINISH:  begin busy_d = 1'b1; done_d = 1'b1; end
      default: begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

`ifdef LINECLEAR_COMBO_EN
  // Combo bonus uses the value before this evaluation increments it.
  always_comb begin
    bonus_s      = '0;
    combo_next_s = 4'd0;
    if (count_q != '0) begin
      bonus_s = SUM_W'(combo_q);
      if (combo_q == COMBO_MAX) begin
        combo_next_s = combo_q;
      end else begin
        combo_next_s = combo_q + 4'd1;
      end
    end else begin
      bonus_s      = '0;
      combo_next_s = 4'd0;
    end
  end
`else
  // Combo disabled: no bonus and the counter stays at zero.
  always_comb begin
    bonus_s      = '0;
    combo_next_s = 4'd0;
  end
`endif

  // Accumulator sums one bit wider than the register; the carry selects
  // saturation.
  always_comb begin
    pts_s       = SUM_W'(line_points(32'(count_q)));
    score_sum_s = {1'b0, score_q} + pts_s + bonus_s;
    total_sum_s = {1'b0, total_q} + TOT_W'(count_q);
    if (score_sum_s[SCORE_W]) begin
      score_sat_s = '1;
    end else begin
      score_sat_s = score_sum_s[SCORE_W-1:0];
    end
    if (total_sum_s[LINES_W]) begin
      total_sat_s = '1;
    end else begin
      total_sat_s = total_sum_s[LINES_W-1:0];
    end
  end

  // Datapath next-state: board load, row scan, result and accumulator update.
  always_comb begin
    board_d = board_q;
    row_d   = row_q;
    count_d = count_q;
    lines_d = lines_q;
    score_d = score_q;
    total_d = total_q;
    combo_d = combo_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          board_d = board_i;
          row_d   = ROW_LAST;
          count_d = '0;
        end else begin
          board_d = board_q;
        end
      end
      SCAN: begin
        if (row_full_s) begin
          board_d = shifted_s;
          count_d = count_q + CNT_W'(1);
        end else if (row_q != '0) begin
          row_d = row_q - RW'(1);
        end else begin
          row_d = row_q;
        end
      end
      FINISH: begin
        lines_d = count_q;
        score_d = score_sat_s;
        total_d = total_sat_s;
        combo_d = combo_next_s;
      end
      default: begin
        board_d = board_q;
      end
    endcase
    // A clear overrides any accumulator update in the same cycle.
    if (clear_score_i) begin
      score_d = '0;
      total_d = '0;
      combo_d = 4'd0;
    end else begin
      score_d = score_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      board_q <= '0;
      row_q   <= ROW_LAST;
      count_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      total_q <= '0;
      combo_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      board_q <= board_d;
      row_q   <= row_d;
      count_q <= count_d;
      lines_q <= lines_d;
      score_q <= score_d;
      total_q <= total_d;
      combo_q <= combo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign board_o         = board_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign lines_cleared_o = lines_q;
  assign score_o         = score_q;
  assign total_lines_o   = total_q;
  assign combo_o         = combo_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// -----------------------------------------------------------------------------
// tb_line_clear_engine
// Directed bench for line_clear_engine. A reference model computes each
// evaluation's result directly (full-row count, compacted board, timeline of
// ROWS+n scan cycles) and a compare process checks both instances every cycle.
// A second instance with narrow accumulators exercises saturation.
// -----------------------------------------------------------------------------
module tb_line_clear_engine;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int CNT_W = $clog2(ROWS + 1);

`ifdef LINECLEAR_COMBO_EN
  localparam bit COMBO_ON = 1'b1;
`else
  localparam bit COMBO_ON = 1'b0;
`endif

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   clear_score = 1'b0;
  board_t board_in = '0;

  board_t           board_o, board_o_s;
  logic             busy, done, busy_s, done_s;
  logic [CNT_W-1:0] lines, lines_s;
  logic [15:0]      score, total;
  logic [3:0]       score_s;
  logic [2:0]       total_s;
  logic [3:0]       combo, combo_s;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(16), .LINES_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_score_i(clear_score),
    .board_i(board_in), .board_o(board_o), .busy_o(busy), .done_o(done),
    .lines_cleared_o(lines), .score_o(score), .total_lines_o(total), .combo_o(combo)
  );

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(4), .LINES_W(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_score_i(clear_score),
    .board_i(board_in), .board_o(board_o_s), .busy_o(busy_s), .done_o(done_s),
    .lines_cleared_o(lines_s), .score_o(score_s), .total_lines_o(total_s), .combo_o(combo_s)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int full_rows(input board_t b);
    int n = 0;
    for (int r = 0; r < ROWS; r++) if (b[r] == '1) n++;
    return n;
  endfunction

  // Drop every full row and let the remaining rows settle at the bottom.
  function automatic board_t settle(input board_t b);
    board_t res = '0;
    int w = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r] != '1) begin
        res[w] = b[r];
        w--;
      end
    end
    return res;
  endfunction

  function automatic int pts(input int n);
    if (n == 0) return 0;
    else if (n < 4) return 2 * n - 1;
    else return 2 * n;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  int     m_phase = 0;  // 0 idle, 1 scanning, 2 done cycle
  int     m_timer = 0, m_n = 0, m_lines = 0, m_combo = 0;
  int     m_score = 0, m_total = 0, m_score_s = 0, m_total_s = 0;
  board_t m_board = '0, m_res = '0;
  int     n_in, bonus;
  board_t res_in;

  assign n_in   = full_rows(board_in);
  assign res_in = settle(board_in);
  assign bonus  = (COMBO_ON && m_n > 0) ? m_combo : 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_timer <= 0; m_n <= 0; m_lines <= 0; m_combo <= 0;
      m_score <= 0; m_total <= 0; m_score_s <= 0; m_total_s <= 0;
      m_board <= '0; m_res <= '0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1; m_timer <= ROWS + n_in; m_n <= n_in;
          m_res <= res_in; m_board <= board_in;
        end
      end else if (m_phase == 1) begin
        if (m_timer == 1) begin
          m_phase <= 2; m_board <= m_res;
        end
        m_timer <= m_timer - 1;
      end else begin
        m_phase   <= 0;
        m_lines   <= m_n;
        m_score   <= sat(m_score + pts(m_n) + bonus, 65535);
        m_score_s <= sat(m_score_s + pts(m_n) + bonus, 15);
        m_total   <= sat(m_total + m_n, 65535);
        m_total_s <= sat(m_total_s + m_n, 7);
        if (COMBO_ON) m_combo <= (m_n > 0) ? ((m_combo < 15) ? m_combo + 1 : 15) : 0;
      end
      if (clear_score) begin
        m_score <= 0; m_score_s <= 0; m_total <= 0; m_total_s <= 0; m_combo <= 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 2);
      chk("lines", lines, m_lines);
      chk("score", score, m_score);
      chk("total", total, m_total);
      chk("combo", combo, m_combo);
      chk("done_s", done_s, m_phase == 2);
      chk("score_s", score_s, m_score_s);
      chk("total_s", total_s, m_total_s);
      if (m_phase != 1) chk("board", board_o, m_board);
    end
  end

  // Runs one evaluation; returns start-to-done latency in cycles and leaves
  // the bench one step after the edge that ends the done cycle.
  task automatic run_eval(input board_t b, input bit clr, output int lat);
    board_in = b; start = 1'b1; lat = 0;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("done_seen", done, 1'b1);
    clear_score = clr;
    @(posedge clk); #1; clear_score = 1'b0;
  endtask

  initial begin
    board_t b_a, b_b, b_one, e;
    int lat, dn;

    b_a = '0;
    for (int r = 16; r < ROWS; r++) b_a[r] = '1;
    b_a[15] = 10'b1000000001;
    b_b = '0;
    b_b[19] = '1; b_b[17] = '1; b_b[18] = 10'h001;
    b_one = '0;
    b_one[19] = '1; b_one[18] = 10'h200;

    // Reset values.
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_board", board_o, '0);
    chk("rst_lines", lines, '0);
    chk("rst_score", score, 16'd0);
    chk("rst_combo", combo, 4'd0);
    rst_n = 1'b1; run_chk = 1'b1;
    @(posedge clk); #1;

    // Empty board.
    run_eval('0, 1'b0, lat);
    chk("lat_empty", lat, 21);
    chk("lines_empty", lines, 0);
    chk("score_empty", score, 0);
    chk("board_empty", board_o, '0);

    // Four stacked full rows with a partial row above.
    run_eval(b_a, 1'b0, lat);
    e = '0; e[19] = 10'b1000000001;
    chk("lat_four", lat, 25);
    chk("lines_four", lines, 4);
    chk("score_four", score, 8);
    chk("board_four", board_o, e);

    // Two non-adjacent full rows (back-to-back start).
    run_eval(b_b, 1'b0, lat);
    e = '0; e[19] = 10'h001;
    chk("lat_two", lat, 23);
    chk("lines_two", lines, 2);
    chk("score_two", score, COMBO_ON ? 12 : 11);
    chk("board_two", board_o, e);

    // Single clear, then four more to saturate the narrow instance.
    run_eval(b_one, 1'b0, lat);
    chk("lines_one", lines, 1);
    run_eval(b_a, 1'b0, lat);
    chk("score_main_f", score, COMBO_ON ? 26 : 20);
    chk("score_sat", score_s, 4'd15);
    chk("total_sat", total_s, 3'd7);
    chk("total_main_f", total, 11);

    // Clear coinciding with the finish cycle.
    run_eval(b_b, 1'b1, lat);
    chk("clr_score", score, 0);
    chk("clr_total", total, 0);
    chk("clr_combo", combo, 0);
    chk("clr_lines", lines, 2);

    // Start during scan is ignored.
    board_in = b_a; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk); #1;
    board_in = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dn = 0;
    repeat (60) begin
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    chk("ignored_start_dones", dn, 1);
    chk("ignored_start_lines", lines, 4);

    // Reset in the middle of a scan.
    board_in = b_a; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_score", score, 16'd0);
    chk("mid_rst_lines", lines, '0);
    chk("mid_rst_board", board_o, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    chk("mid_rst_dones", dn, 0);

    // Consecutive single clears, then an empty evaluation.
    clear_score = 1'b1; @(posedge clk); #1; clear_score = 1'b0;
    run_eval(b_one, 1'b0, lat);
    chk("cmb_score1", score, 1);
    chk("cmb_combo1", combo, COMBO_ON ? 1 : 0);
    run_eval(b_one, 1'b0, lat);
    chk("cmb_score2", score, COMBO_ON ? 3 : 2);
    chk("cmb_combo2", combo, COMBO_ON ? 2 : 0);
    run_eval(b_one, 1'b0, lat);
    chk("cmb_score3", score, COMBO_ON ? 6 : 3);
    chk("cmb_combo3", combo, COMBO_ON ? 3 : 0);
    run_eval('0, 1'b0, lat);
    chk("cmb_combo0", combo, 0);
    chk("cmb_score0", score, COMBO_ON ? 6 : 3);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
